// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Size encodings match data_memory's size_in.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Counter reload value, latency clamped to the legal range.
  function automatic logic [1:0] lat_load(input int lat);
    int c;
    c = (lat < RD_LAT_MIN) ? RD_LAT_MIN :
        (lat > RD_LAT_MAX) ? RD_LAT_MAX : lat;
    return 2'(c - 1);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way winner select: fixed CPU priority or
// round-robin against the last granted requester.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int CPU_PRIO = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_winner,
  output logic o_valid
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = REQ_CPU;
    unique case (1'b1)
      (i_req0 & i_req1):
        o_winner = (CPU_PRIO != 0) ? REQ_CPU : ~i_last_gnt;
      (i_req0 & ~i_req1):
        o_winner = REQ_CPU;
      (~i_req0 & i_req1):
        o_winner = REQ_DBG;
      default:
        o_winner = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for the single data_memory port.
// Define DMEM_ARB_PERF_EN for grant/conflict counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_gnt0,
  output logic [31:0]       perf_gnt1,
  output logic [31:0]       perf_conflict
`endif
);

  localparam logic [1:0] LAT_LOAD = lat_load(RD_LAT);

  state_t     r_state;
  logic       r_last_gnt;
  logic       r_win;
  logic       r_we;
  logic [1:0] r_cnt;

  logic              w_winner;
  logic              w_valid;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_size;

  dmem_arb_pick #(
    .CPU_PRIO (CPU_PRIO)
  ) u_pick (
    .i_req0     (req0),
    .i_req1     (req1),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_valid    (w_valid)
  );

  assign w_we    = w_winner ? we1    : we0;
  assign w_addr  = w_winner ? addr1  : addr0;
  assign w_wdata = w_winner ? wdata1 : wdata0;
  assign w_size  = w_winner ? size1  : size0;

  // mem_addr/mem_wdata/mem_size double as the payload latch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last_gnt <= REQ_DBG;
      r_win      <= REQ_CPU;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state    <= ISSUE;
            busy       <= 1'b1;
            r_win      <= w_winner;
            r_last_gnt <= w_winner;
            r_we       <= w_we;
            gnt0       <= (w_winner == REQ_CPU);
            gnt1       <= (w_winner == REQ_DBG);
            mem_we     <= w_we;
            mem_re     <= ~w_we;
            mem_addr   <= w_addr;
            mem_wdata  <= w_wdata;
            mem_size   <= w_size;
          end
        end
        ISSUE: begin
          if (r_we) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= RESP;
            rdata   <= mem_rdata;
            rvalid0 <= (r_win == REQ_CPU);
            rvalid1 <= (r_win == REQ_DBG);
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_gnt0     <= '0;
      perf_gnt1     <= '0;
      perf_conflict <= '0;
    end else if (r_state == IDLE) begin
      if (w_valid && w_winner == REQ_CPU)
        perf_gnt0 <= perf_gnt0 + 32'd1;
      if (w_valid && w_winner == REQ_DBG)
        perf_gnt1 <= perf_gnt1 + 32'd1;
      if (req0 && req1)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench: two arbiters (RR/lat1 and prio/lat3) with
// latency-accurate memory models and a grant/read scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        req0 [2];
  logic        req1 [2];
  logic        we0 [2];
  logic        we1 [2];
  logic [31:0] addr0 [2];
  logic [31:0] addr1 [2];
  logic [31:0] wdata0 [2];
  logic [31:0] wdata1 [2];
  logic [1:0]  size0 [2];
  logic [1:0]  size1 [2];
  logic        gnt0 [2];
  logic        gnt1 [2];
  logic        rvalid0 [2];
  logic        rvalid1 [2];
  logic        busy [2];
  logic        mem_re [2];
  logic        mem_we [2];
  logic [31:0] rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [1:0]  mem_size [2];
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_gnt0 [2];
  logic [31:0] perf_gnt1 [2];
  logic [31:0] perf_conflict [2];
`endif

  int checks = 0;
  int failures = 0;
  int n_gnt [2];
  logic [63:0] q_gnt [2][$];
  logic [63:0] q_rd [2][$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] pipe [3];

    always @(posedge clock) begin
      pipe[0] <= mem_re[g] ? memf(mem_addr[g]) : 32'hBAD0_BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = pipe[LAT-1];

    dmem_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RD_LAT   (LAT),
      .CPU_PRIO (g)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .req0      (req0[g]),
      .req1      (req1[g]),
      .we0       (we0[g]),
      .we1       (we1[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wdata0[g]),
      .wdata1    (wdata1[g]),
      .size0     (size0[g]),
      .size1     (size1[g]),
      .gnt0      (gnt0[g]),
      .gnt1      (gnt1[g]),
      .rvalid0   (rvalid0[g]),
      .rvalid1   (rvalid1[g]),
      .rdata     (rdata[g]),
      .busy      (busy[g]),
      .mem_re    (mem_re[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_size  (mem_size[g]),
      .mem_rdata (mem_rdata[g])
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_gnt0     (perf_gnt0[g]),
      .perf_gnt1     (perf_gnt1[g]),
      .perf_conflict (perf_conflict[g])
`endif
    );

    // Scoreboard: every grant and read response must be expected.
    always @(posedge clock) begin
      #1;
      if (reset) begin
        if (gnt0[g] || gnt1[g]) begin
          n_gnt[g]++;
          chk($sformatf("gnt_excl%0d", g),
              64'(gnt0[g] & gnt1[g]), 64'd0);
          chk($sformatf("gnt_order%0d", g), {63'b0, gnt1[g]},
              (q_gnt[g].size() != 0) ? q_gnt[g].pop_front()
                                     : 64'hDEAD);
        end
        if (rvalid0[g] || rvalid1[g]) begin
          chk($sformatf("rd_resp%0d", g),
              {31'b0, rvalid1[g], rdata[g]},
              (q_rd[g].size() != 0) ? q_rd[g].pop_front()
                                    : 64'hDEAD_DEAD_DEAD_DEAD);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_gnt(input int g, input int target);
    int n;
    n = 0;
    while (n_gnt[g] < target && n < 80) begin
      step();
      n++;
    end
    chk($sformatf("wait_gnt%0d", g), 64'(n_gnt[g] >= target), 64'd1);
  endtask

  task automatic wait_drain(input int g);
    int n;
    n = 0;
    while ((q_gnt[g].size() != 0 || q_rd[g].size() != 0 || busy[g])
           && n < 80) begin
      step();
      n++;
    end
    chk($sformatf("drain%0d", g),
        64'(q_gnt[g].size() + q_rd[g].size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    for (int g = 0; g < 2; g++) begin
      req0[g] = 0; req1[g] = 0; we0[g] = 0; we1[g] = 0;
      addr0[g] = '0; addr1[g] = '0;
      wdata0[g] = '0; wdata1[g] = '0;
      size0[g] = SZ_WORD; size1[g] = SZ_WORD;
      n_gnt[g] = 0;
    end
    reset = 0;
    step();
    step();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_busy%0d", g), 64'(busy[g]), 64'd0);
      chk($sformatf("rst_gnt%0d", g), 64'(gnt0[g] | gnt1[g]), 64'd0);
      chk($sformatf("rst_strb%0d", g), 64'(mem_re[g] | mem_we[g]), 64'd0);
      chk($sformatf("rst_rv%0d", g), 64'(rvalid0[g] | rvalid1[g]), 64'd0);
      chk($sformatf("rst_addr%0d", g), 64'(mem_addr[g]), 64'd0);
      chk($sformatf("rst_rdata%0d", g), 64'(rdata[g]), 64'd0);
    end
    reset = 1;
    step();

    // Single write from requester 0
    req0[0] = 1; we0[0] = 1;
    addr0[0] = 32'h1000_0004; wdata0[0] = 32'hDEAD_BEEF;
    size0[0] = SZ_HALF;
    q_gnt[0].push_back(64'd0);
    step();
    chk("wr_gnt0", 64'(gnt0[0]), 64'd1);
    chk("wr_we", 64'(mem_we[0]), 64'd1);
    chk("wr_re", 64'(mem_re[0]), 64'd0);
    chk("wr_addr", 64'(mem_addr[0]), 64'h1000_0004);
    chk("wr_wdata", 64'(mem_wdata[0]), 64'hDEAD_BEEF);
    chk("wr_size", 64'(mem_size[0]), 64'(SZ_HALF));
    chk("wr_busy", 64'(busy[0]), 64'd1);
    req0[0] = 0;
    step();
    chk("wr_idle", 64'(busy[0]), 64'd0);
    chk("wr_we_clr", 64'(mem_we[0]), 64'd0);
    chk("wr_addr_hold", 64'(mem_addr[0]), 64'h1000_0004);

    // Single read from requester 1, latency 1
    req1[0] = 1; we1[0] = 0; addr1[0] = 32'h2000_0010;
    q_gnt[0].push_back(64'd1);
    q_rd[0].push_back({31'b0, 1'b1, memf(32'h2000_0010)});
    step();
    chk("rd_gnt1", 64'(gnt1[0]), 64'd1);
    chk("rd_re", 64'(mem_re[0]), 64'd1);
    req1[0] = 0;
    step();
    chk("rd_re_clr", 64'(mem_re[0]), 64'd0);
    chk("rd_early", 64'(rvalid1[0]), 64'd0);
    step();
    chk("rd_rvalid1", 64'(rvalid1[0]), 64'd1);
    chk("rd_rvalid0", 64'(rvalid0[0]), 64'd0);
    chk("rd_data", 64'(rdata[0]), 64'(memf(32'h2000_0010)));
    step();
    chk("rd_pulse", 64'(rvalid1[0]), 64'd0);
    chk("rd_hold", 64'(rdata[0]), 64'(memf(32'h2000_0010)));
    chk("rd_idle", 64'(busy[0]), 64'd0);

    // Round-robin with both requesters reading continuously
    addr0[0] = 32'h0000_0300; addr1[0] = 32'h0000_0400;
    we0[0] = 0; we1[0] = 0;
    for (int i = 0; i < 2; i++) begin
      q_gnt[0].push_back(64'd0);
      q_gnt[0].push_back(64'd1);
      q_rd[0].push_back({32'b0, memf(32'h0000_0300)});
      q_rd[0].push_back({31'b0, 1'b1, memf(32'h0000_0400)});
    end
    base = n_gnt[0];
    req0[0] = 1; req1[0] = 1;
    wait_gnt(0, base + 4);
    req0[0] = 0; req1[0] = 0;
    wait_drain(0);

    // Reset while a read is in WAIT
    req0[0] = 1; we0[0] = 0; addr0[0] = 32'h0000_0500;
    q_gnt[0].push_back(64'd0);
    step();
    chk("mr_gnt0", 64'(gnt0[0]), 64'd1);
    req0[0] = 0;
    step();
    chk("mr_wait_busy", 64'(busy[0]), 64'd1);
    reset = 0;
    step();
    reset = 1;
    chk("mr_busy", 64'(busy[0]), 64'd0);
    chk("mr_strb", 64'(mem_re[0] | mem_we[0]), 64'd0);
    chk("mr_rv", 64'(rvalid0[0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_rv", 64'(rvalid0[0]), 64'd0);
    end
    req0[0] = 1; addr0[0] = 32'h0000_0600;
    q_gnt[0].push_back(64'd0);
    q_rd[0].push_back({32'b0, memf(32'h0000_0600)});
    base = n_gnt[0];
    wait_gnt(0, base + 1);
    req0[0] = 0;
    wait_drain(0);

    // Latency-3 conflicting read on the priority instance
    req0[1] = 1; req1[1] = 1; we0[1] = 0; we1[1] = 0;
    addr0[1] = 32'h0000_0700; addr1[1] = 32'h0000_0800;
    q_gnt[1].push_back(64'd0);
    q_rd[1].push_back({32'b0, memf(32'h0000_0700)});
    step();
    chk("l3_gnt0", 64'(gnt0[1]), 64'd1);
    chk("l3_gnt1", 64'(gnt1[1]), 64'd0);
    chk("l3_re", 64'(mem_re[1]), 64'd1);
    req0[1] = 0; req1[1] = 0;
    step();
    step();
    step();
    chk("l3_early", 64'(rvalid0[1]), 64'd0);
    step();
    chk("l3_rvalid0", 64'(rvalid0[1]), 64'd1);
    chk("l3_data", 64'(rdata[1]), 64'(memf(32'h0000_0700)));
`ifdef DMEM_ARB_PERF_EN
    chk("perf_conflict", 64'(perf_conflict[1]), 64'd1);
    chk("perf_gnt0", 64'(perf_gnt0[1]), 64'd1);
    chk("perf_gnt1", 64'(perf_gnt1[1]), 64'd0);
`endif
    step();
    chk("l3_idle", 64'(busy[1]), 64'd0);

    // Fixed priority: requester 1 waits until requester 0 drops
    we0[1] = 1; we1[1] = 1;
    q_gnt[1].push_back(64'd0);
    q_gnt[1].push_back(64'd0);
    q_gnt[1].push_back(64'd0);
    q_gnt[1].push_back(64'd1);
    base = n_gnt[1];
    req0[1] = 1; req1[1] = 1;
    wait_gnt(1, base + 3);
    req0[1] = 0;
    wait_gnt(1, base + 4);
    req1[1] = 0;
    wait_drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
